line_window_buffer: RTL

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

---
 rtl/line_window_buffer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/line_window_buffer.sv
// 3x3 sliding-window generator for raster video, built from two row line buffers.
// Optional feature: define LWB_WIN_COUNT_EN to add the saturating win_count output.
module line_window_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   pixel_in,
    input  logic                pixel_valid,
    input  logic                frame_start,
    output logic [9*DATA_W-1:0] win_out,
    output logic                win_valid,
`ifdef LWB_WIN_COUNT_EN
    output logic [15:0]         win_count,
`endif
    output logic                frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0]    col, col_p0, col_next;
    logic [ROW_W-1:0]    row, row_p0, row_next;
    logic                vld_p0, sof_p0, emit_p0, last_p0;
    logic [DATA_W-1:0]   lb1 [IMG_W];
    logic [DATA_W-1:0]   lb2 [IMG_W];
    logic [DATA_W-1:0]   lb1_rd, lb2_rd;
    logic [DATA_W-1:0]   taps [9];
    logic [DATA_W-1:0]   taps_next [9];
    logic [9*DATA_W-1:0] taps_flat;

    // Stage p0: position of the incoming pixel; an accepted frame_start forces (0,0).
    assign vld_p0  = pixel_valid;
    assign sof_p0  = pixel_valid & frame_start;
    assign col_p0  = sof_p0 ? '0 : col;
    assign row_p0  = sof_p0 ? '0 : row;
    assign lb1_rd  = lb1[col_p0];
    assign lb2_rd  = lb2[col_p0];
    assign emit_p0 = vld_p0 && (row_p0 >= ROW_TWO) && (col_p0 >= COL_TWO);
    assign last_p0 = vld_p0 && (row_p0 == ROW_LAST) && (col_p0 == COL_LAST);

    always_comb begin
        col_next = col_p0 + COL_W'(1);
        row_next = row_p0;
        if (col_p0 == COL_LAST) begin
            col_next = '0;
            row_next = (row_p0 == ROW_LAST) ? '0 : row_p0 + ROW_W'(1);
        end
    end

    always_comb begin
        taps_next[0] = taps[1];
        taps_next[1] = taps[2];
        taps_next[2] = lb2_rd;
        taps_next[3] = taps[4];
        taps_next[4] = taps[5];
        taps_next[5] = lb1_rd;
        taps_next[6] = taps[7];
        taps_next[7] = taps[8];
        taps_next[8] = pixel_in;
        taps_flat    = '0;
        for (int k = 0; k < 9; k++) begin
            taps_flat[k*DATA_W +: DATA_W] = taps_next[k];
        end
    end

    // Stage p1: registered window, valid and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_out    <= '0;
            for (int k = 0; k < 9; k++) begin
                taps[k] <= '0;
            end
        end else begin
            win_valid  <= emit_p0;
            frame_done <= last_p0;
            if (vld_p0) begin
                col <= col_next;
                row <= row_next;
                for (int k = 0; k < 9; k++) begin
                    taps[k] <= taps_next[k];
                end
            end
            if (emit_p0) begin
                win_out <= taps_flat;
            end
        end
    end

    // Line buffers are never reset: rows 0 and 1 of every frame overwrite them
    // before any window at row 2 can read them.
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            lb2[col_p0] <= lb1_rd;
            lb1[col_p0] <= pixel_in;
        end
    end

`ifdef LWB_WIN_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count <= '0;
        end else if (sof_p0) begin
            win_count <= '0;
        end else if (emit_p0 && (win_count != 16'hFFFF)) begin
            win_count <= win_count + 16'd1;
        end
    end
`endif

endmodule
